// File: rtl/character_motion_pkg.sv
// Shared types and screen constants for character motion.
// Used by the motion controller, its interface and the renderer.
package character_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WALK    = 2'd1,
        ATTACK  = 2'd2,
        RECOVER = 2'd3
    } char_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int POS_W    = 10;

endpackage

// File: rtl/character_motion_if.sv
// Key inputs, frame strobe and motion outputs of one character.
// master: keyboard/frame source side; slave: motion controller.
interface character_motion_if;
    import character_pkg::*;

    logic              frame_clk;
    logic              move_l;
    logic              move_r;
    logic              attack;
    logic [POS_W-1:0]  pos_x;
    logic              facing_right;
    char_state_t       char_state;
    logic [1:0]        anim_frame;
    logic              attack_active;
    logic              busy;

    modport master (
        output frame_clk, move_l, move_r, attack,
        input  pos_x, facing_right, char_state,
        input  anim_frame, attack_active, busy
    );

    modport slave (
        input  frame_clk, move_l, move_r, attack,
        output pos_x, facing_right, char_state,
        output anim_frame, attack_active, busy
    );

endinterface

// File: rtl/frame_tick_gen.sv
// One-Clk tick on each 0->1 transition of the vsync-rate frame_clk.
// Ports: Clk, Reset (sync, active-high), frame_clk in, frame_tick out.
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic frame_tick
);

    logic frame_clk_d;
    logic armed;

    // armed stays low while a level that was already high at reset
    // release persists, so only a genuine low->high edge ticks.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_clk_d <= 1'b0;
            armed       <= ~frame_clk;
        end else begin
            frame_clk_d <= frame_clk;
            armed       <= armed | ~frame_clk;
        end
    end

    assign frame_tick = frame_clk & ~frame_clk_d & armed;

endmodule

// File: rtl/character_motion.sv
// Per-character IDLE/WALK/ATTACK/RECOVER controller, one step per frame.
// Ports: Clk, Reset (sync, active-high), bus (keys in, motion out).
module character_motion
    import character_pkg::*;
#(
    parameter int X_MIN          = 0,
    parameter int X_MAX          = 560,
    parameter int X_START        = 100,
    parameter int STEP           = 2,
    parameter int ATTACK_FRAMES  = 12,
    parameter int RECOVER_FRAMES = 6,
    parameter int HIT_START      = 4,
    parameter int HIT_END        = 7,
    parameter int ANIM_DIV       = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    character_motion_if.slave  bus
);

    localparam logic [4:0]  ATK_LAST  = 5'(ATTACK_FRAMES - 1);
    localparam logic [4:0]  REC_LAST  = 5'(RECOVER_FRAMES - 1);
    localparam logic [4:0]  HIT_LO    = 5'(HIT_START);
    localparam logic [4:0]  HIT_HI    = 5'(HIT_END);
    localparam logic [3:0]  WALK_LAST = 4'(ANIM_DIV - 1);
    localparam logic [10:0] LO_LIM    = 11'(X_MIN + STEP);
    localparam logic [10:0] HI_LIM    = 11'(X_MAX);
    localparam logic [10:0] STEP_W    = 11'(STEP);
    localparam logic [9:0]  X_MIN_P   = 10'(X_MIN);
    localparam logic [9:0]  X_MAX_P   = 10'(X_MAX);
    localparam logic [9:0]  X_START_P = 10'(X_START);

    logic        frame_tick;
    char_state_t state_q, state_d;
    logic [9:0]  pos_q, pos_d;
    logic        face_q, face_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [1:0]  anim_q, anim_d;
    logic        act_q, act_d;
    logic        prev_q;
    logic        busy_q;
    logic        press;
    logic [10:0] pos_ext;
    logic [10:0] pos_inc;
    logic [2:0]  cnt_quarter;

    frame_tick_gen u_tick (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (bus.frame_clk),
        .frame_tick (frame_tick)
    );

    assign press   = bus.attack & ~prev_q;
    // 11-bit arithmetic so clamping never sees a wrapped value
    assign pos_ext = {1'b0, pos_q};
    assign pos_inc = pos_ext + STEP_W;

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        face_d      = face_q;
        cnt_d       = cnt_q;
        wcnt_d      = wcnt_q;
        anim_d      = anim_q;
        act_d       = 1'b0;
        cnt_quarter = 3'd0;
        unique case (state_q)
            IDLE, WALK: begin
                if (press) begin
                    state_d = ATTACK;
                    cnt_d   = 5'd0;
                    anim_d  = 2'd0;
                end else if (bus.move_l ^ bus.move_r) begin
                    state_d = WALK;
                    face_d  = bus.move_r;
                    if (bus.move_r) begin
                        pos_d = (pos_inc > HI_LIM) ? X_MAX_P : pos_inc[9:0];
                    end else begin
                        pos_d = (pos_ext < LO_LIM) ? X_MIN_P
                                                   : pos_q - 10'(STEP);
                    end
                    if (wcnt_q == WALK_LAST) begin
                        wcnt_d = 4'd0;
                        anim_d = anim_q + 2'd1;
                    end else begin
                        wcnt_d = wcnt_q + 4'd1;
                    end
                end else begin
                    state_d = IDLE;
                    anim_d  = 2'd0;
                    wcnt_d  = 4'd0;
                end
            end
            ATTACK: begin
                if (cnt_q == ATK_LAST) begin
                    state_d = RECOVER;
                    cnt_d   = 5'd0;
                    anim_d  = 2'd3;
                end else begin
                    cnt_d       = cnt_q + 5'd1;
                    cnt_quarter = cnt_d[4:2];
                    anim_d      = (cnt_quarter > 3'd3) ? 2'd3
                                                       : cnt_quarter[1:0];
                    act_d       = (cnt_d >= HIT_LO) && (cnt_d <= HIT_HI);
                end
            end
            RECOVER: begin
                anim_d = 2'd3;
                if (cnt_q == REC_LAST) begin
                    state_d = IDLE;
                    cnt_d   = 5'd0;
                    anim_d  = 2'd0;
                    wcnt_d  = 4'd0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pos_q   <= X_START_P;
            face_q  <= 1'b1;
            cnt_q   <= 5'd0;
            wcnt_q  <= 4'd0;
            anim_q  <= 2'd0;
            act_q   <= 1'b0;
            prev_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else if (frame_tick) begin
            state_q <= state_d;
            pos_q   <= pos_d;
            face_q  <= face_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            anim_q  <= anim_d;
            act_q   <= act_d;
            prev_q  <= bus.attack;
            busy_q  <= (state_d == ATTACK) || (state_d == RECOVER);
        end
    end

    assign bus.pos_x         = pos_q;
    assign bus.facing_right  = face_q;
    assign bus.char_state    = state_q;
    assign bus.anim_frame    = anim_q;
    assign bus.attack_active = act_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_character_motion.sv
// Self-checking bench for character_motion.
// Table vectors plus a per-tick scoreboard and corner-case sequences.
module tb_character_motion;
    import character_pkg::*;

    typedef struct packed {
        logic [9:0] pos;
        logic       face;
        logic [1:0] st;
        logic [1:0] anim;
        logic       act;
        logic       busy;
    } obs_t;

    typedef struct {
        bit   l;
        bit   r;
        bit   a;
        obs_t exp;
    } vec_t;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    character_motion_if bus ();

    character_motion dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    obs_t q[$];
    obs_t last;
    vec_t tbl[10];

    int m_pos, m_face, m_state, m_cnt, m_wcnt, m_anim, m_act, m_prev;

    localparam obs_t RST_OBS = {10'd100, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0};

    function automatic obs_t sample();
        return {bus.pos_x, bus.facing_right, bus.char_state,
                bus.anim_frame, bus.attack_active, bus.busy};
    endfunction

    function automatic obs_t model_obs();
        return {10'(m_pos), 1'(m_face), 2'(m_state), 2'(m_anim),
                1'(m_act), 1'(m_state >= 2)};
    endfunction

    function automatic vec_t mk(bit l, bit r, bit a, int pos, bit face,
                                int st, int anim, bit act, bit busy);
        vec_t v;
        v.l = l;
        v.r = r;
        v.a = a;
        v.exp = {10'(pos), face, 2'(st), 2'(anim), act, busy};
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 100; m_face = 1; m_state = 0; m_cnt = 0;
        m_wcnt = 0; m_anim = 0; m_act = 0; m_prev = 0;
    endtask

    task automatic model_tick(bit l, bit r, bit a);
        bit press;
        press = a && (m_prev == 0);
        m_prev = a;
        m_act = 0;
        case (m_state)
            0, 1: begin
                if (press) begin
                    m_state = 2; m_cnt = 0; m_anim = 0;
                end else if (l != r) begin
                    m_state = 1;
                    m_face = r;
                    if (l) m_pos = (m_pos < 2) ? 0 : m_pos - 2;
                    else m_pos = (m_pos + 2 > 560) ? 560 : m_pos + 2;
                    m_wcnt++;
                    if (m_wcnt == 8) begin
                        m_wcnt = 0;
                        m_anim = (m_anim + 1) % 4;
                    end
                end else begin
                    m_state = 0; m_anim = 0; m_wcnt = 0;
                end
            end
            2: begin
                m_cnt++;
                if (m_cnt == 12) begin
                    m_state = 3; m_cnt = 0; m_anim = 3;
                end else begin
                    m_anim = (m_cnt / 4 > 3) ? 3 : m_cnt / 4;
                    m_act = (m_cnt >= 4 && m_cnt <= 7) ? 1 : 0;
                end
            end
            default: begin
                m_cnt++;
                if (m_cnt == 6) begin
                    m_state = 0; m_cnt = 0; m_anim = 0; m_wcnt = 0;
                end
            end
        endcase
    endtask

    // one frame tick; expectation queued at drive, compared at output
    task automatic tick(bit l, bit r, bit a, bit use_exp, obs_t exp);
        obs_t e;
        @(negedge Clk);
        bus.move_l = l;
        bus.move_r = r;
        bus.attack = a;
        bus.frame_clk = 1'b1;
        model_tick(l, r, a);
        q.push_back(use_exp ? exp : model_obs());
        @(negedge Clk);
        bus.frame_clk = 1'b0;
        last = sample();
        if (q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = q.pop_front();
            chk("tick", 32'(last), 32'(e));
        end
    endtask

    task automatic do_reset(bit fc);
        @(negedge Clk);
        Reset = 1'b1;
        bus.frame_clk = fc;
        bus.move_l = 1'b0;
        bus.move_r = 1'b0;
        bus.attack = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int busy_n, act_n, entries;
        logic [1:0] pst;
        bus.frame_clk = 1'b0;
        bus.move_l = 1'b0;
        bus.move_r = 1'b0;
        bus.attack = 1'b0;
        model_reset();

        tbl[0] = mk(0, 0, 0, 100, 1, 0, 0, 0, 0);
        tbl[1] = mk(0, 0, 0, 100, 1, 0, 0, 0, 0);
        tbl[2] = mk(0, 0, 0, 100, 1, 0, 0, 0, 0);
        tbl[3] = mk(0, 1, 0, 102, 1, 1, 0, 0, 0);
        tbl[4] = mk(0, 1, 0, 104, 1, 1, 0, 0, 0);
        tbl[5] = mk(0, 1, 0, 106, 1, 1, 0, 0, 0);
        tbl[6] = mk(1, 1, 0, 106, 1, 0, 0, 0, 0);
        tbl[7] = mk(1, 0, 0, 104, 0, 1, 0, 0, 0);
        tbl[8] = mk(1, 0, 0, 102, 0, 1, 0, 0, 0);
        tbl[9] = mk(0, 0, 0, 102, 0, 0, 0, 0, 0);

        do_reset(1'b0);
        chk("reset_state", 32'(sample()), 32'(RST_OBS));
        for (int i = 0; i < 10; i++)
            tick(tbl[i].l, tbl[i].r, tbl[i].a, 1'b1, tbl[i].exp);

        // outputs hold between ticks
        tick(0, 1, 0, 1'b0, '0);
        @(negedge Clk);
        bus.move_l = 1'b1;
        bus.attack = 1'b1;
        repeat (4) @(negedge Clk);
        chk("hold_between_ticks", 32'(sample()), 32'(last));
        bus.attack = 1'b0;

        // walk left into the X_MIN clamp
        do_reset(1'b0);
        for (int i = 1; i <= 60; i++) begin
            tick(1, 0, 0, 1'b0, '0);
            if (i == 8)  chk("anim_step_8", 32'(last.anim), 32'd1);
            if (i == 32) chk("anim_wrap_32", 32'(last.anim), 32'd0);
            if (i == 50) chk("pos_at_50", 32'(last.pos), 32'd0);
        end
        chk("pos_clamped_60", 32'(last.pos), 32'd0);
        chk("face_left", 32'(last.face), 32'd0);

        // both move keys -> IDLE, position unchanged
        for (int i = 0; i < 3; i++) tick(1, 1, 0, 1'b0, '0);
        chk("both_idle", 32'({last.st, last.anim}), 32'({2'd0, 2'd0}));
        chk("both_pos", 32'(last.pos), 32'd0);

        // single attack with move_r held
        do_reset(1'b0);
        busy_n = 0;
        act_n = 0;
        for (int i = 1; i <= 22; i++) begin
            tick(1'b0, 1'b1, i == 1, 1'b0, '0);
            busy_n += int'(last.busy);
            act_n += int'(last.act);
            if (i == 18) chk("pos_frozen", 32'(last.pos), 32'd100);
            if (i == 6) chk("hit_count4", 32'(last.act), 32'd1);
            if (i == 9) chk("hit_count8", 32'(last.act), 32'd0);
        end
        chk("busy_ticks", 32'(busy_n), 32'd18);
        chk("active_ticks", 32'(act_n), 32'd4);

        // attack held for 40 ticks -> exactly one cycle
        do_reset(1'b0);
        entries = 0;
        pst = 2'd0;
        for (int i = 0; i < 40; i++) begin
            tick(0, 0, 1, 1'b0, '0);
            if (last.st == 2'd2 && pst != 2'd2) entries++;
            pst = last.st;
        end
        chk("single_attack", 32'(entries), 32'd1);
        chk("held_idle", 32'(last.st), 32'd0);
        tick(0, 0, 0, 1'b0, '0);

        // reset mid-attack with frame_clk held high through release
        do_reset(1'b0);
        tick(0, 0, 1, 1'b0, '0);
        for (int i = 0; i < 5; i++) tick(0, 0, 0, 1'b0, '0);
        chk("mid_attack_act", 32'({last.st, last.act}), 32'({2'd2, 1'b1}));
        do_reset(1'b1);
        chk("abort_reset", 32'(sample()), 32'(RST_OBS));
        bus.move_r = 1'b1;
        repeat (3) @(negedge Clk);
        chk("no_tick_high", 32'(bus.pos_x), 32'd100);
        bus.frame_clk = 1'b0;
        tick(0, 1, 0, 1'b0, '0);
        chk("tick_after_fall", 32'(last.pos), 32'd102);

        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
